// File: rtl/lat_seq_pkg.sv
// Shared types and constants for the gated-latch write sequencer: FSM state
// encoding, default phase lengths and a constant clog2 helper.
package lat_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        GATE  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_LATCH = 4;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_GATE_CYC  = 2;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_write_sequencer_phase_timer.sv
// Loadable down-counter used to time every sequencer phase; zero marks the
// last cycle of the current phase.
module phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Counter: reload on phase entry, otherwise count down and stick at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Phased write of one gated latch: data setup, gate window, data hold, done.
// Optional build macro LATCH_READBACK_EN adds lat_q and a readback compare.
module latch_write_sequencer
    import lat_seq_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_LATCH = DEF_NUM_LATCH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int GATE_CYC  = DEF_GATE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    localparam int ADDR_W   = (NUM_LATCH > 1) ? clog2(NUM_LATCH) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef LATCH_READBACK_EN
    input  logic [NUM_LATCH*DATA_W-1:0] lat_q,
`endif
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [DATA_W-1:0]           lat_d,
    output logic [NUM_LATCH-1:0]        lat_gate,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int CNT_W = clog2(max3(SETUP_CYC, GATE_CYC, HOLD_CYC)) + 1;

    state_e                 state_r;
    state_e                 next_state_s;
    logic                   load_s;
    logic [CNT_W-1:0]       load_val_s;
    logic                   zero_s;
    logic                   accept_s;
    logic [ADDR_W-1:0]      addr_r;
    logic [31:0]            addr_ext_s;
    logic                   addr_oor_s;
    logic [NUM_LATCH-1:0]   gate_dec_s;
    logic                   err_cond_s;
    logic                   wr_ready_r;
    logic [DATA_W-1:0]      lat_d_r;
    logic [NUM_LATCH-1:0]   lat_gate_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .zero     (zero_s)
    );

    assign accept_s   = (state_r == IDLE) && wr_valid;
    assign addr_ext_s = 32'(addr_r);
    assign addr_oor_s = (addr_ext_s >= 32'(NUM_LATCH));

    // Next-state logic; the timer is reloaded with (length-1) on every entry
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_val_s   = '0;
        case (state_r)
            IDLE: begin
                if (wr_valid) begin
                    next_state_s = SETUP;
                    load_s       = 1'b1;
                    load_val_s   = CNT_W'(SETUP_CYC - 1);
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                if (zero_s) begin
                    next_state_s = GATE;
                    load_s       = 1'b1;
                    load_val_s   = CNT_W'(GATE_CYC - 1);
                end else begin
                    next_state_s = SETUP;
                end
            end
            GATE: begin
                if (zero_s) begin
                    next_state_s = HOLD;
                    load_s       = 1'b1;
                    load_val_s   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    next_state_s = GATE;
                end
            end
            HOLD: begin
                if (zero_s) begin
                    next_state_s = DONE;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = HOLD;
                end
            end
            DONE: begin
                next_state_s = IDLE;
                load_s       = 1'b1;
            end
            default: begin
                next_state_s = IDLE;
                load_s       = 1'b1;
            end
        endcase
    end

    // One-hot gate decode; an out-of-range index never raises any gate
    always_comb begin
        gate_dec_s = '0;
        if (addr_oor_s) begin
            gate_dec_s = '0;
        end else begin
            for (int i = 0; i < NUM_LATCH; i++) begin
                gate_dec_s[i] = (addr_ext_s == 32'(i));
            end
        end
    end

`ifdef LATCH_READBACK_EN
    logic [DATA_W-1:0] rb_word_s;

    // Select the addressed latch output for the readback compare
    always_comb begin
        rb_word_s = '0;
        for (int i = 0; i < NUM_LATCH; i++) begin
            if (addr_ext_s == 32'(i)) begin
                rb_word_s = lat_q[i*DATA_W +: DATA_W];
            end else begin
                rb_word_s = rb_word_s;
            end
        end
    end

    // lat_q is sampled during the last HOLD cycle, after the gate has closed
    assign err_cond_s = addr_oor_s || (rb_word_s != lat_d_r);
`else
    assign err_cond_s = addr_oor_s;
`endif

    // Registered outputs follow the state being entered, so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            wr_ready_r <= 1'b1;
            lat_d_r    <= '0;
            lat_gate_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            addr_r     <= '0;
        end else begin
            state_r    <= next_state_s;
            wr_ready_r <= (next_state_s == IDLE);
            busy_r     <= (next_state_s != IDLE);
            lat_gate_r <= (next_state_s == GATE) ? gate_dec_s : '0;
            done_r     <= (next_state_s == DONE);
            err_r      <= (next_state_s == DONE) && err_cond_s;
            if (accept_s) begin
                addr_r  <= wr_addr;
                lat_d_r <= wr_data;
            end else begin
                addr_r  <= addr_r;
                lat_d_r <= lat_d_r;
            end
        end
    end

    assign wr_ready = wr_ready_r;
    assign lat_d    = lat_d_r;
    assign lat_gate = lat_gate_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: a default instance and a 3-latch instance
// with 3/1/2 phases, both driven by the same random stream, checked per cycle.
module tb_latch_write_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;

    logic       rdy0, busy0, done0, err0;
    logic       rdy1, busy1, done1, err1;
    logic [7:0] latd0, latd1;
    logic [3:0] gate0;
    logic [2:0] gate1;

    int n_checks = 0;
    int n_errors = 0;

    int   p_n [2] = '{4, 3};
    int   p_s [2] = '{1, 3};
    int   p_g [2] = '{2, 1};
    int   p_h [2] = '{1, 2};
    bit   m_act [2];
    int   m_k [2];
    int   m_a [2];
    logic [7:0] m_d [2];
    logic [7:0] mem [2][4];

    always #5 clk = ~clk;

`ifdef LATCH_READBACK_EN
    logic [31:0] lat_q0;
    logic [23:0] lat_q1;
    // latch 0 of the default instance is stuck at zero
    assign lat_q0 = {mem[0][3], mem[0][2], mem[0][1], 8'h00};
    assign lat_q1 = {mem[1][2], mem[1][1], mem[1][0]};
`endif

    latch_write_sequencer dut0 (
        .clk      (clk),
        .reset    (reset),
`ifdef LATCH_READBACK_EN
        .lat_q    (lat_q0),
`endif
        .wr_valid (wr_valid),
        .wr_ready (rdy0),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lat_d    (latd0),
        .lat_gate (gate0),
        .busy     (busy0),
        .done     (done0),
        .err      (err0)
    );

    latch_write_sequencer #(
        .NUM_LATCH (3),
        .SETUP_CYC (3),
        .GATE_CYC  (1),
        .HOLD_CYC  (2)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
`ifdef LATCH_READBACK_EN
        .lat_q    (lat_q1),
`endif
        .wr_valid (wr_valid),
        .wr_ready (rdy1),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lat_d    (latd1),
        .lat_gate (gate1),
        .busy     (busy1),
        .done     (done1),
        .err      (err1)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Expected outputs from the position k within a write of length S+G+H+1
    task automatic check_all();
        for (int j = 0; j < 2; j++) begin
            int          len;
            logic [3:0]  e_gate;
            logic        e_done, e_err, rb_bad;
            logic [3:0]  a_gate;
            len    = p_s[j] + p_g[j] + p_h[j] + 1;
            e_gate = 4'd0;
            if (m_act[j] && m_k[j] > p_s[j] && m_k[j] <= p_s[j] + p_g[j] && m_a[j] < p_n[j])
                e_gate = 4'd1 << m_a[j];
            e_done = m_act[j] && (m_k[j] == len);
            rb_bad = 1'b0;
`ifdef LATCH_READBACK_EN
            rb_bad = (j == 0) && (m_a[j] == 0) && (m_d[j] != 8'h00);
`endif
            e_err  = e_done && ((m_a[j] >= p_n[j]) || rb_bad);
            a_gate = (j == 0) ? gate0 : {1'b0, gate1};
            check_val($sformatf("wr_ready%0d", j), {31'd0, (j == 0) ? rdy0 : rdy1}, {31'd0, ~m_act[j]});
            check_val($sformatf("busy%0d", j), {31'd0, (j == 0) ? busy0 : busy1}, {31'd0, m_act[j]});
            check_val($sformatf("done%0d", j), {31'd0, (j == 0) ? done0 : done1}, {31'd0, e_done});
            check_val($sformatf("err%0d", j), {31'd0, (j == 0) ? err0 : err1}, {31'd0, e_err});
            check_val($sformatf("lat_d%0d", j), {24'd0, (j == 0) ? latd0 : latd1}, {24'd0, m_d[j]});
            check_val($sformatf("lat_gate%0d", j), {28'd0, a_gate}, {28'd0, e_gate});
            for (int i = 0; i < 4; i++) begin
                if (a_gate[i]) mem[j][i] = (j == 0) ? latd0 : latd1;
            end
        end
    endtask

    // Advance one clock, update the reference model with the applied request
    task automatic tick();
        bit         v;
        int         a;
        logic [7:0] d;
        v = wr_valid;
        a = int'(wr_addr);
        d = wr_data;
        @(posedge clk);
        for (int j = 0; j < 2; j++) begin
            if (!m_act[j]) begin
                if (v) begin
                    m_act[j] = 1'b1;
                    m_k[j]   = 1;
                    m_d[j]   = d;
                    m_a[j]   = a;
                end
            end else begin
                m_k[j] = m_k[j] + 1;
                if (m_k[j] > p_s[j] + p_g[j] + p_h[j] + 1) m_act[j] = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_act[j] = 1'b0;
            m_k[j]   = 0;
            m_a[j]   = 0;
            m_d[j]   = 8'h00;
        end
    endtask

    task automatic wait_idle();
        int budget;
        budget   = 0;
        wr_valid = 1'b0;
        while ((m_act[0] || m_act[1]) && budget < 30) begin
            tick();
            budget = budget + 1;
        end
        check_val("idle_wait", {31'd0, m_act[0] | m_act[1]}, 32'd0);
    endtask

    task automatic write_once(input logic [1:0] a, input logic [7:0] d);
        wait_idle();
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    initial begin
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) mem[j][i] = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Basic write, then out-of-range and readback targets
        write_once(2'd2, 8'hA5);
        write_once(2'd3, 8'hFF);
        write_once(2'd0, 8'h5A);
        write_once(2'd1, 8'h5A);

        // Request held high across a running write: no queueing, re-accept after DONE
        wait_idle();
        wr_valid = 1'b1;
        wr_addr  = 2'd0;
        wr_data  = 8'h11;
        tick();
        wr_data  = 8'h3C;
        for (int c = 0; c < 10; c++) tick();
        wait_idle();

        // Reset during the first gate cycle of the default instance
        wr_valid = 1'b1;
        wr_addr  = 2'd1;
        wr_data  = 8'h96;
        tick();
        wr_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_val("async_gate0", {28'd0, gate0}, 32'd0);
        check_val("async_gate1", {29'd0, gate1}, 32'd0);
        check_val("async_ready0", {31'd0, rdy0}, 32'd1);
        check_val("async_lat_d0", {24'd0, latd0}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) tick();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_addr  = 2'($urandom_range(0, 3));
            wr_data  = 8'($urandom);
            tick();
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
